// File: rtl/mau_pkg.sv
// Shared definitions for the MAU host load/store paths: opcodes, instruction
// field layout and the store-unit state encoding.
package mau_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned SEL_LSB = 6;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned OP_LSB  = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PRESENT,
        DONE
    } store_state_e;

    // Decoded view of host_instruction
    typedef struct packed {
        logic [SEL_W-1:0] bram;
        opcode_e          op;
    } instr_dec_t;

endpackage

// File: rtl/mau_instr_decode.sv
// Combinational split of host_instruction into BRAM index and opcode.
// Shared by the load and store units.
module mau_instr_decode
    import mau_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output instr_dec_t         dec_c
);

    // Bits [5:4] and [1:0] carry no meaning for either unit
    logic unused_bits;
    assign unused_bits = ^{instr[5:4], instr[1:0]};

    always_comb begin
        dec_c.bram = instr[SEL_LSB +: SEL_W];
        dec_c.op   = opcode_e'(instr[OP_LSB +: OP_W]);
    end

endmodule

// File: rtl/mau_store_unit.sv
// Host read-out path of the MAU: on STORE, streams one MATRIX_DIM x MATRIX_DIM
// byte matrix from the selected BRAM to the host, one byte per handshake.
module mau_store_unit
    import mau_pkg::*;
#(
    parameter int unsigned MATRIX_DIM = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  host_instruction,
    input  logic                host_ready,
    input  logic [DATA_W-1:0]   bram_rd_data,
    output logic [SEL_W-1:0]    bram_sel,
    output logic                bram_rd_en,
    output logic [ADDR_W-1:0]   bram_rd_addr,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                busy_flag,
    output logic                done_pulse
);

    localparam int unsigned     NUM_BYTES = MATRIX_DIM * MATRIX_DIM;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    instr_dec_t         dec_c;
    store_state_e       state;
    store_state_e       state_d;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  addr_d;
    logic [SEL_W-1:0]   sel_d;
    logic [DATA_W-1:0]  data_d;
    logic               rd_en_d;
    logic               valid_d;
    logic               busy_d;
    logic               done_d;

    mau_instr_decode u_decode (
        .instr (host_instruction),
        .dec_c (dec_c)
    );

    assign bram_rd_addr = addr;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, datapath updates and next-cycle output values
    always_comb begin
        state_d = state;
        addr_d  = addr;
        sel_d   = bram_sel;
        data_d  = data_out;

        case (state)
            IDLE: begin
                if (dec_c.op == OP_STORE) begin
                    sel_d   = dec_c.bram;
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                data_d  = bram_rd_data;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (host_ready) begin
                    // Terminal count checked before increment: no wrap
                    if (addr == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                // Wait for STORE to drop so a held instruction cannot re-trigger
                if (dec_c.op != OP_STORE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_en_d = (state_d == FETCH);
        valid_d = (state_d == PRESENT);
        busy_d  = (state_d == FETCH) || (state_d == LATCH) || (state_d == PRESENT);
        done_d  = (state_d == DONE) && (state != DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr       <= '0;
            bram_sel   <= '0;
            data_out   <= '0;
            bram_rd_en <= 1'b0;
            data_valid <= 1'b0;
            busy_flag  <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            addr       <= addr_d;
            bram_sel   <= sel_d;
            data_out   <= data_d;
            bram_rd_en <= rd_en_d;
            data_valid <= valid_d;
            busy_flag  <= busy_d;
            done_pulse <= done_d;
        end
    end

endmodule

// File: doc/mau_store_unit.md
Name: mau_store_unit

Overview:
- Host-facing read-out path of the Matrix Algebra Unit. It is the reverse of the host LOAD path.
- On a STORE instruction it streams one MATRIX_DIM x MATRIX_DIM matrix of bytes from the selected BRAM (0-3) to the host over data_out.
- Each byte is qualified by data_valid and accepted by host_ready. busy_flag is held for the whole transfer.
- Sits beside the load unit inside MAU. It shares the host_instruction bus and the BRAM read mux.

Parameters:
- MATRIX_DIM, 8, matrix side length; the transfer is MATRIX_DIM*MATRIX_DIM bytes.
- DATA_W, 8, element width in bits.
- ADDR_W, 6, BRAM byte-address width; must equal clog2(MATRIX_DIM*MATRIX_DIM).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- host_instruction  in  8  [7:6] BRAM select, [3:2] opcode (00 NOP, 01 LOAD, 10 STORE, 11 reserved), other bits ignored.
- host_ready  in  1  host accepts data_out this cycle when data_valid=1.
- bram_rd_data  in  DATA_W  read data from the BRAM selected by bram_sel; valid the cycle after bram_rd_en.
- bram_sel  out  2  BRAM index, latched at start of transfer.
- bram_rd_en  out  1  read strobe, one cycle per byte.
- bram_rd_addr  out  ADDR_W  byte address; byte k = ram[DATA_W*k +: DATA_W].
- data_out  out  DATA_W  byte presented to host.
- data_valid  out  1  data_out holds a valid byte.
- busy_flag  out  1  transfer in progress.
- done_pulse  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; internal address and bram_sel latch 0.
- States:
  - IDLE: busy=0. If opcode==STORE, latch [7:6] into bram_sel, clear addr, go to FETCH. Any other opcode, stay in IDLE.
  - FETCH: bram_rd_en=1 with bram_rd_addr=addr, for one cycle; go to LATCH.
  - LATCH: bram_rd_data is valid; register it into data_out at the clock edge; go to PRESENT.
  - PRESENT: data_valid=1; data_out held stable.
    - host_ready=0: stay in PRESENT.
    - host_ready=1 and addr==MATRIX_DIM*MATRIX_DIM-1: go to DONE.
    - host_ready=1 otherwise: addr+1, go to FETCH.
  - DONE: busy=0, data_valid=0; done_pulse=1 for the first DONE cycle only. Stay in DONE while opcode==STORE; go to IDLE once opcode!=STORE. A held instruction therefore never re-triggers.
- busy_flag=1 in FETCH, LATCH and PRESENT.
  - Rises the cycle after STORE is sampled in IDLE.
  - With host_ready tied 1: 3 cycles per byte, busy high exactly 3*MATRIX_DIM^2 cycles (192 at default).
- data_valid=0 in FETCH and LATCH; data_out keeps its last value outside PRESENT.
- bram_rd_en is never asserted while data_valid=1. There is no prefetch, so no skid buffer is needed.
- The address does not wrap; the terminal count is detected before the increment.
- host_instruction changes mid-transfer (other BRAM, NOP, LOAD) are ignored until DONE.
- Top-level arbitration guarantees LOAD and STORE are never active together. This block does not check it.
- Reset mid-transfer: immediate return to reset values; the next STORE restarts at address 0.
- Reserved opcode 11: treated as NOP.

Decomposition:
- Shared package mau_pkg (also used by the load unit):
  - opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_RSVD;
  - instruction field positions (BRAM select [7:6], opcode [3:2]);
  - the store-unit state enum (IDLE, FETCH, LATCH, PRESENT, DONE).
- One natural sub-module, mau_instr_decode: combinational decode of host_instruction into bram index and opcode strobes. It is shared with the load unit.
- The FSM and address counter stay in mau_store_unit.

Test Plan:
- Reset values: drive rst=0 mid-clock -> all outputs 0 immediately. With rst=1 and instruction 8'h00 for 20 cycles -> busy_flag stays 0 and no bram_rd_en.
- Full read: preload BRAM 2 with byte k = k+1, host_ready=1, instruction 8'b10_00_10_00 ->
  - bram_sel=2;
  - 64 data_valid beats carrying 1..64 in order;
  - busy high exactly 192 cycles;
  - one done_pulse.
- Backpressure: drop host_ready for 5 cycles while byte 10 (value 11) is presented ->
  - data_out stays 11 with data_valid=1;
  - no bram_rd_en during the stall;
  - the stream resumes at 12; busy extends to 197 cycles.
- Held instruction: keep STORE asserted 20 cycles past DONE -> no second transfer. Drop to NOP, then STORE again -> the transfer restarts from address 0.
- Mid-op instruction change: switch host_instruction to BRAM 1 STORE at byte 30 -> bram_sel stays 2 and values continue 31..64.
- Reset mid-op: assert rst at byte 20 -> outputs clear. A fresh STORE to BRAM 0 (byte k = 0xA0+k) -> first byte 0xA0, 64 beats.
